// File: rtl/skinny_sbox_layer_scheduler.sv
// Time-multiplexes one masked Skinny-64 S-box gadget across every nibble of a
// two-share state, holding gadget inputs and randomness stable for its latency.
module skinny_sbox_layer_scheduler #(
  parameter int NIBBLES      = 16,
  parameter int SBOX_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   state_s0,
  input  logic [4*NIBBLES-1:0]   state_s1,
  input  logic [3:0]             rnd_in,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  output logic [3:0]             sb_in_s0,
  output logic [3:0]             sb_in_s1,
  output logic [3:0]             sb_fresh,
  input  logic [3:0]             sb_out_s0,
  input  logic [3:0]             sb_out_s1,
  output logic [4*NIBBLES-1:0]   res_s0,
  output logic [4*NIBBLES-1:0]   res_s1,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW = (SBOX_LATENCY > 1) ? $clog2(SBOX_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EVAL    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  logic [4*NIBBLES-1:0] r_sh0;
  logic [4*NIBBLES-1:0] r_sh1;
  logic [4*NIBBLES-1:0] r_res0;
  logic [4*NIBBLES-1:0] r_res1;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_sb_s0;
  logic [3:0]           r_sb_s1;
  logic [3:0]           r_fresh;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rnd_ready;

  logic                 w_last_nibble;
  logic                 w_eval_last;

  assign w_last_nibble = (r_idx == IW'(NIBBLES - 1));
  assign w_eval_last   = (r_cnt == CW'(SBOX_LATENCY - 1));

  // Share 0 and share 1 live in separate registers end to end; they are never
  // combined, so the gadget inputs only move on the FETCH->EVAL edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_sb_s0     <= '0;
      r_sb_s1     <= '0;
      r_fresh     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rnd_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh0       <= state_s0;
            r_sh1       <= state_s1;
            r_idx       <= '0;
            r_res0      <= '0;
            r_res1      <= '0;
            r_busy      <= 1'b1;
            r_rnd_ready <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rnd_valid) begin
            r_sb_s0     <= r_sh0[4*r_idx +: 4];
            r_sb_s1     <= r_sh1[4*r_idx +: 4];
            r_fresh     <= rnd_in;
            r_cnt       <= '0;
            r_rnd_ready <= 1'b0;
            r_state     <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_eval_last) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_res0[4*r_idx +: 4] <= sb_out_s0;
          r_res1[4*r_idx +: 4] <= sb_out_s1;
          if (w_last_nibble) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx       <= r_idx + 1'b1;
            r_rnd_ready <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_rnd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rnd_ready = r_rnd_ready;
  assign sb_in_s0  = r_sb_s0;
  assign sb_in_s1  = r_sb_s1;
  assign sb_fresh  = r_fresh;
  assign res_s0    = r_res0;
  assign res_s1    = r_res1;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/skinny_sbox_layer_scheduler.md
# skinny_sbox_layer_scheduler

Sequencer that time-multiplexes one first-order masked Skinny-64 S-box gadget across all nibbles of a two-share cipher state. It hands one nibble at a time to the gadget, together with 4 bits of fresh randomness. Inputs and randomness are held stable for the gadget's full latency, and each output nibble is collected into a result register. It sits between the round-function datapath and the shared masked S-box instance, replacing 16 parallel gadgets in area-optimised builds.

## Interface
- NIBBLES, 16, number of 4-bit S-box evaluations per layer (state width = 4*NIBBLES)
- SBOX_LATENCY, 2, cycles from gadget input change to valid gadget output (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- state_s0  in  4*NIBBLES  share 0 of input state, sampled at start
- state_s1  in  4*NIBBLES  share 1 of input state, sampled at start
- rnd_in  in  4  fresh randomness for one gadget evaluation
- rnd_valid  in  1  rnd_in is valid
- rnd_ready  out  1  scheduler accepts rnd_in this cycle
- sb_in_s0 / sb_in_s1  out  4 each  gadget input shares (registered)
- sb_fresh  out  4  gadget randomness (registered)
- sb_out_s0 / sb_out_s1  in  4 each  gadget output shares
- res_s0 / res_s1  out  4*NIBBLES  result shares (registered)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result complete

## Operation
- States: IDLE, FETCH, EVAL, CAPTURE, DONE.
- IDLE, start=1:
  - latch state_s0/state_s1 into internal share registers
  - idx←0
  - clear res_s0/res_s1
  - next state FETCH
- FETCH:
  - rnd_ready=1
  - if rnd_valid: sb_in_s0/sb_in_s1 ← nibble idx of the latched shares, bits [4*idx+3:4*idx]
  - also sb_fresh←rnd_in, cnt←0, next state EVAL
  - else stay in FETCH indefinitely (stall); no other register changes
- EVAL:
  - cnt increments each cycle
  - when cnt==SBOX_LATENCY-1, next state CAPTURE
  - sb_in_*/sb_fresh are held constant throughout
- CAPTURE:
  - res nibble idx ← sb_out_s0/sb_out_s1
  - if idx==NIBBLES-1: next state DONE
  - else idx←idx+1, next state FETCH
- DONE: done=1 for one cycle, then IDLE.
- Nibble 0 (LSB nibble) is processed first.
- Shares are never combined. Share-0 and share-1 paths stay in separate registers.
- sb_in_*/sb_fresh change only on the FETCH→EVAL edge. They retain their last value in all other states, so there are no glitching transitions into the gadget.
- rnd_ready is 0 outside FETCH. rnd_in is ignored outside FETCH.
- start while busy is ignored. start in the DONE cycle is ignored.
- res_s0/res_s1:
  - hold the final result from the DONE cycle until the next accepted start
  - partial values during busy are not meaningful
- Reset (any time, including mid-layer) → IDLE. Reset values:
  - all registers 0
  - busy=0, done=0, rnd_ready=0
  - sb_in_*=0, sb_fresh=0, res_*=0

## Timing
- start accepted at edge t0. busy=1 from cycle t0+1.
- Per nibble, with rnd_valid constantly high: FETCH 1 + EVAL SBOX_LATENCY + CAPTURE 1 = SBOX_LATENCY+2 cycles.
- done is high in cycle t0+1+NIBBLES*(SBOX_LATENCY+2). This is cycle 65 for the defaults.
- busy falls in the cycle after done. start is accepted again from that cycle.
- Each cycle rnd_valid is low in FETCH adds exactly one cycle.
- The gadget output is sampled exactly SBOX_LATENCY cycles after sb_in_* change.

## Test plan
- Unmasked layer (defaults, behavioural 2-cycle masked S-box in bench):
  - stimulus: state_s0=0x0123456789ABCDEF, state_s1=0, rnd_valid=1, pulse start
  - required: done in cycle 65 after start edge; res_s0^res_s1=0xC6901A2B385D4E7F
- Random masking:
  - stimulus: state_s1=random R, state_s0=0x0123456789ABCDEF^R, random rnd_in
  - required: same unshared result; sb_in_s0^sb_in_s1 equals the expected nibble in every EVAL cycle
- Randomness stall:
  - stimulus: drop rnd_valid for 3 cycles during FETCH of nibble 5
  - required: done 3 cycles later (68); sb_in_* unchanged during the stall; result correct
- Stability check:
  - sb_in_*/sb_fresh toggle only on FETCH→EVAL edges, giving exactly 16 updates per layer
  - rnd_ready is high only in FETCH
- start during busy:
  - stimulus: assert start at cycles 10 and 65
  - required: both ignored; single done pulse; result unchanged
- Mid-layer reset:
  - stimulus: assert rst=0 at cycle 30
  - required: busy, done, sb_* and res_* all 0; FSM in IDLE
  - then release reset and start a new layer; required: it completes correctly in 65 cycles
